block_transfer_sequencer: RTL and testbench
===========================================

Name: block_transfer_sequencer

Overview:
Parametrised LDM/STM micro-sequencer for the ARM7 execute stage. It accepts a decoded block-transfer request: base address, register list, and the P/U/L/W bits. It then issues one word bus request per listed register in ascending register order, with a valid/ready handshake. On completion it reports the writeback base value. It generalises the fixed 16-bit block reg_list field to NUM_REGS registers and implements the empty-list quirk of the ARM7TDMI.

Parameters:
ADDR_WIDTH, 32, bus address and base-register width
NUM_REGS, 16, register-list width; highest index is the PC-equivalent used for the empty list
WORD_BYTES, 4, address stride per transfer
IDX_W, $clog2(NUM_REGS), width of register index (derived, not overridable)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
start_valid  in  1  request present
start_ready  out  1  sequencer idle, request accepted when start_valid & start_ready
base_addr  in  ADDR_WIDTH  value of Rn
reg_list  in  NUM_REGS  register mask, bit i = register i
pre  in  1  P bit: 1 = pre-index (IB/DB)
up  in  1  U bit: 1 = ascending base (IA/IB)
load  in  1  L bit: 1 = LDM, 0 = STM
writeback  in  1  W bit
abort  in  1  synchronous cancel of the in-flight sequence
bus_valid  out  1  transfer request
bus_ready  in  1  bus accepts request this cycle
bus_addr  out  ADDR_WIDTH  word address of current transfer
bus_write  out  1  1 for STM, 0 for LDM
reg_idx  out  IDX_W  register being transferred
done  out  1  one-cycle completion pulse
wb_valid  out  1  with done: base update required (writeback latched)
wb_addr  out  ADDR_WIDTH  with done: new base value
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is asynchronous and active-high.
- Reset values: all registers clear, state=IDLE. Outputs: start_ready=1, busy=0, bus_valid=0, done=0, wb_valid=0, bus_addr=0, reg_idx=0, wb_addr=0, bus_write=0.
- FSM states: IDLE, CALC, XFER, DONE.
- IDLE:
  - start_ready=1.
  - On handshake, latch all request fields and go to CALC.
- CALC (1 cycle):
  - n = popcount(reg_list).
  - If n==0, treat the list as {NUM_REGS-1} for transfers, and use N = NUM_REGS for address arithmetic. Otherwise N = n.
  - Compute offset = N*WORD_BYTES, truncated to ADDR_WIDTH.
  - Compute the start address:
    - IA = base
    - IB = base+WORD_BYTES
    - DA = base-offset+WORD_BYTES
    - DB = base-offset
  - Compute wb_addr = up ? base+offset : base-offset.
  - Go to XFER.
- XFER:
  - bus_valid=1.
  - reg_idx = lowest set bit of the remaining mask.
  - bus_write = ~load.
  - On bus_valid & bus_ready: clear that bit and advance bus_addr by WORD_BYTES.
  - When the cleared bit was the last one, go to DONE.
  - While bus_ready=0, bus_addr, reg_idx and bus_write hold stable.
- Address ordering: always ascending, lowest register at the lowest address, for all four modes.
- Arithmetic wraps modulo 2^ADDR_WIDTH.
- DONE (1 cycle):
  - done=1, wb_valid=latched writeback, wb_addr valid.
  - Next state IDLE.
  - No back-to-back acceptance: start_ready=0 in DONE.
- abort:
  - In CALC or XFER: next state IDLE, no done pulse, bus_valid drops next cycle.
  - Abort coincident with the final bus handshake: abort wins, no done.
  - Ignored in IDLE and DONE.
- Latency with bus_ready tied high: handshake at cycle 0, CALC cycle 1, transfers cycles 2..N'+1 (N' = transfers issued), done at cycle N'+2.
- Reset mid-operation: immediate return to reset values, no done.

Test Plan:
- STMIA base=0x0300_0000, list=0x000F, W=1, bus_ready=1 -> bus_addr 0x03000000/04/08/0C, reg_idx 0,1,2,3, bus_write=1, done at cycle 6, wb_valid=1, wb_addr=0x03000010.
- LDMDB base=0x0300_0100, list=0x8003 -> addrs 0x030000F4/F8/FC, reg_idx 0,1,15, bus_write=0, wb_addr=0x030000F4.
- LDMIB base=0x1000, list=0x0010 and STMDA base=0x1000, list=0x0030 -> IB: addr 0x1004, wb 0x1004; DA: addrs 0x0FFC,0x1000, reg_idx 4,5, wb 0x0FF8.
- Empty list: IA base=0x2000 -> single transfer reg_idx 15 at 0x2000, wb 0x2040. DB base=0x2000 -> addr 0x1FC0, wb 0x1FC0.
- Backpressure: list=0x0006 with bus_ready low 3 cycles on the first request -> bus_addr/reg_idx held (idx 1) until ready, then idx 2; exactly 2 handshakes, one done pulse.
- abort asserted during the second transfer of list=0x00FF -> IDLE next cycle, no done, start_ready=1. Separately, reset asserted mid-XFER -> bus_valid=0 and busy=0 immediately.

Source files
------------

// File: rtl/block_transfer_sequencer.sv
// LDM/STM block-transfer micro-sequencer: walks a register mask in ascending order,
// issuing one word bus request per register and reporting the written-back base.
module block_transfer_sequencer #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int NUM_REGS   = 16,
  parameter  int WORD_BYTES = 4,
  localparam int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [NUM_REGS-1:0]   reg_list,
  input  logic                  pre,
  input  logic                  up,
  input  logic                  load,
  input  logic                  writeback,
  input  logic                  abort,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_write,
  output logic [IDX_W-1:0]      reg_idx,
  output logic                  done,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  busy
);

  localparam int                    CNT_W    = $clog2(NUM_REGS + 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(WORD_BYTES);
  localparam logic [NUM_REGS-1:0]   TOP_MASK = {1'b1, {(NUM_REGS-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [NUM_REGS-1:0]   mask_q, mask_d;
  logic                  pre_q, pre_d;
  logic                  up_q, up_d;
  logic                  load_q, load_d;
  logic                  wb_q, wb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;

  logic [CNT_W-1:0]      cnt_s;
  logic [IDX_W-1:0]      idx_s;
  logic [ADDR_WIDTH-1:0] n_eff_s;
  logic [ADDR_WIDTH-1:0] offset_s;
  logic [NUM_REGS-1:0]   mask_clr_s;

  // Popcount of the mask and index of its lowest set bit.
  always_comb begin
    cnt_s = '0;
    idx_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_s = cnt_s + CNT_W'(mask_q[i]);
    end
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      idx_s = mask_q[i] ? IDX_W'(i) : idx_s;
    end
    // An empty list still spans NUM_REGS words of address space (ARM7TDMI quirk).
    n_eff_s    = (cnt_s == '0) ? ADDR_WIDTH'(NUM_REGS) : ADDR_WIDTH'(cnt_s);
    offset_s   = n_eff_s * STRIDE;
    mask_clr_s = mask_q & (mask_q - NUM_REGS'(1));
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    mask_d    = mask_q;
    pre_d     = pre_q;
    up_d      = up_q;
    load_d    = load_q;
    wb_d      = wb_q;
    addr_d    = addr_q;
    wb_addr_d = wb_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          base_d  = base_addr;
          mask_d  = reg_list;
          pre_d   = pre;
          up_d    = up;
          load_d  = load;
          wb_d    = writeback;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          case ({pre_q, up_q})
            2'b01:   addr_d = base_q;
            2'b11:   addr_d = base_q + STRIDE;
            2'b00:   addr_d = base_q - offset_s + STRIDE;
            2'b10:   addr_d = base_q - offset_s;
            default: addr_d = base_q;
          endcase
          wb_addr_d = up_q ? (base_q + offset_s) : (base_q - offset_s);
          if (cnt_s == '0) begin
            mask_d = TOP_MASK;
          end else begin
            mask_d = mask_q;
          end
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bus_ready) begin
          mask_d  = mask_clr_s;
          addr_d  = addr_q + STRIDE;
          state_d = (mask_clr_s == '0) ? S_DONE : S_XFER;
        end else begin
          state_d = S_XFER;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      mask_q    <= '0;
      pre_q     <= 1'b0;
      up_q      <= 1'b0;
      load_q    <= 1'b0;
      wb_q      <= 1'b0;
      addr_q    <= '0;
      wb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      mask_q    <= mask_d;
      pre_q     <= pre_d;
      up_q      <= up_d;
      load_q    <= load_d;
      wb_q      <= wb_d;
      addr_q    <= addr_d;
      wb_addr_q <= wb_addr_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign bus_valid   = (state_q == S_XFER);
  assign bus_write   = (state_q == S_XFER) & ~load_q;
  assign bus_addr    = addr_q;
  assign reg_idx     = idx_s;
  assign done        = (state_q == S_DONE);
  assign wb_valid    = (state_q == S_DONE) & wb_q;
  assign wb_addr     = wb_addr_q;

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Directed self-checking bench for block_transfer_sequencer.
module tb_block_transfer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] base_addr;
  logic [15:0] reg_list;
  logic        pre, up, load, writeback, abort;
  logic        bus_valid, bus_ready, bus_write;
  logic [31:0] bus_addr;
  logic [3:0]  reg_idx;
  logic        done, wb_valid, busy;
  logic [31:0] wb_addr;

  int n_checks = 0;
  int n_errors = 0;
  int hs_count = 0;
  int done_count = 0;
  int h0, d0;

  block_transfer_sequencer #(.ADDR_WIDTH(32), .NUM_REGS(16), .WORD_BYTES(4)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .base_addr(base_addr), .reg_list(reg_list), .pre(pre), .up(up), .load(load),
    .writeback(writeback), .abort(abort), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_addr(bus_addr), .bus_write(bus_write), .reg_idx(reg_idx), .done(done),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_valid && bus_ready) hs_count <= hs_count + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request, then sample the CALC cycle.
  task automatic start_req(input logic [31:0] b, input logic [15:0] l,
                           input logic p, input logic u, input logic ld, input logic w);
    @(negedge clk);
    base_addr = b; reg_list = l; pre = p; up = u; load = ld; writeback = w;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    chk("calc_busy", 32'(busy), 32'd1);
    chk("calc_no_bus", 32'(bus_valid), 32'd0);
  endtask

  task automatic expect_xfer(input logic [31:0] a, input logic [3:0] idx, input logic wr);
    @(negedge clk);
    chk("xfer_valid", 32'(bus_valid), 32'd1);
    chk("xfer_addr", bus_addr, a);
    chk("xfer_idx", 32'(reg_idx), 32'(idx));
    chk("xfer_write", 32'(bus_write), 32'(wr));
  endtask

  task automatic expect_done(input logic wbv, input logic [31:0] wba);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_wb_valid", 32'(wb_valid), 32'(wbv));
    chk("done_wb_addr", wb_addr, wba);
    chk("done_not_ready", 32'(start_ready), 32'd0);
    @(negedge clk);
    chk("post_done_low", 32'(done), 32'd0);
    chk("post_ready", 32'(start_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start_valid = 1'b0; base_addr = 32'd0; reg_list = 16'd0;
    pre = 1'b0; up = 1'b0; load = 1'b0; writeback = 1'b0; abort = 1'b0; bus_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_reg_idx", 32'(reg_idx), 32'd0);
    chk("rst_wb_addr", wb_addr, 32'd0);
    chk("rst_bus_write", 32'(bus_write), 32'd0);
    reset = 1'b0;

    // STMIA, done lands at cycle 6
    start_req(32'h0300_0000, 16'h000F, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_xfer(32'h0300_0000, 4'd0, 1'b1);
    expect_xfer(32'h0300_0004, 4'd1, 1'b1);
    expect_xfer(32'h0300_0008, 4'd2, 1'b1);
    expect_xfer(32'h0300_000C, 4'd3, 1'b1);
    expect_done(1'b1, 32'h0300_0010);

    // LDMDB
    start_req(32'h0300_0100, 16'h8003, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_xfer(32'h0300_00F4, 4'd0, 1'b0);
    expect_xfer(32'h0300_00F8, 4'd1, 1'b0);
    expect_xfer(32'h0300_00FC, 4'd15, 1'b0);
    expect_done(1'b1, 32'h0300_00F4);

    // LDMIB and STMDA
    start_req(32'h0000_1000, 16'h0010, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_xfer(32'h0000_1004, 4'd4, 1'b0);
    expect_done(1'b1, 32'h0000_1004);
    start_req(32'h0000_1000, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_xfer(32'h0000_0FFC, 4'd4, 1'b1);
    expect_xfer(32'h0000_1000, 4'd5, 1'b1);
    expect_done(1'b1, 32'h0000_0FF8);

    // Empty list: IA (no writeback) and DB
    start_req(32'h0000_2000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_xfer(32'h0000_2000, 4'd15, 1'b0);
    expect_done(1'b0, 32'h0000_2040);
    start_req(32'h0000_2000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_xfer(32'h0000_1FC0, 4'd15, 1'b0);
    expect_done(1'b1, 32'h0000_1FC0);

    // Backpressure on the first request
    bus_ready = 1'b0;
    d0 = done_count;
    start_req(32'h0000_0100, 16'h0006, 1'b0, 1'b1, 1'b0, 1'b0);
    h0 = hs_count;
    expect_xfer(32'h0000_0100, 4'd1, 1'b1);
    expect_xfer(32'h0000_0100, 4'd1, 1'b1);
    expect_xfer(32'h0000_0100, 4'd1, 1'b1);
    expect_xfer(32'h0000_0100, 4'd1, 1'b1);
    bus_ready = 1'b1;
    expect_xfer(32'h0000_0104, 4'd2, 1'b1);
    expect_done(1'b0, 32'h0000_0108);
    chk("bp_handshakes", 32'(hs_count - h0), 32'd2);
    chk("bp_done_pulses", 32'(done_count - d0), 32'd1);

    // Abort during second transfer
    d0 = done_count;
    start_req(32'h0000_0000, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_xfer(32'h0000_0000, 4'd0, 1'b1);
    expect_xfer(32'h0000_0004, 4'd1, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_bus_valid", 32'(bus_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(start_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("abort_no_done", 32'(done_count - d0), 32'd0);

    // Abort coincident with the final handshake wins
    d0 = done_count;
    start_req(32'h0000_0080, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_xfer(32'h0000_0080, 4'd0, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_last_busy", 32'(busy), 32'd0);
    chk("abort_last_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("abort_last_no_done", 32'(done_count - d0), 32'd0);

    // Abort in DONE is ignored
    d0 = done_count;
    start_req(32'h0000_0040, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_xfer(32'h0000_0040, 4'd0, 1'b1);
    @(negedge clk);
    abort = 1'b1;
    chk("abort_in_done", 32'(done), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_done_idle", 32'(start_ready), 32'd1);
    chk("abort_in_done_count", 32'(done_count - d0), 32'd1);

    // Reset mid-XFER
    d0 = done_count;
    start_req(32'h0000_0500, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_xfer(32'h0000_0500, 4'd0, 1'b1);
    expect_xfer(32'h0000_0504, 4'd1, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(start_ready), 32'd1);
    chk("mid_rst_bus_addr", bus_addr, 32'd0);
    chk("mid_rst_wb_addr", wb_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_no_done", 32'(done_count - d0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
